// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DM_WAIT = 2'b01,
    ST_ERR     = 2'b10
  } state_e;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // Write-back source of an instruction: ALU result or memory load data
  localparam logic LW_ALU_SRC = 1'b0;
  localparam logic LW_MEM_SRC = 1'b1;

  // Value on memwb_bubble that turns the MEM/WB entry into a non-writing bubble
  localparam logic WRITE_DISABLE = 1'b1;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding compare for one EX operand: picks EX/MEM, MEM/WB or regfile.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_src_addr_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_lwsrc_i,
  input  logic [REG_AW-1:0] mem_write_addr_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_write_addr_i,
  output logic [1:0]        fwd_sel_o
);

  logic src_nonzero_s;
  assign src_nonzero_s = (ex_src_addr_i != {REG_AW{1'b0}});

  // Youngest producer wins; a load in MEM has no result yet, so it never forwards from EX/MEM
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (src_nonzero_s && mem_reg_write_i && (mem_lwsrc_i == LW_ALU_SRC) &&
        (mem_write_addr_i == ex_src_addr_i)) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (src_nonzero_s && wb_reg_write_i && (wb_write_addr_i == ex_src_addr_i)) begin
      fwd_sel_o = FWD_MEMWB;
    end else begin
      fwd_sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with a
// data-memory wait timeout that latches into a sticky error state.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DM_TIMEOUT = 15,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic              id_rs_used_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic              id_rt_used_i,
  input  logic [REG_AW-1:0] ex_rs_addr_i,
  input  logic [REG_AW-1:0] ex_rt_addr_i,
  input  logic              ex_reg_write_i,
  input  logic              ex_lwsrc_i,
  input  logic [REG_AW-1:0] ex_write_addr_i,
  input  logic              mem_reg_write_i,
  input  logic              mem_lwsrc_i,
  input  logic [REG_AW-1:0] mem_write_addr_i,
  input  logic              mem_access_i,
  input  logic              dm_ready_i,
  input  logic              branch_taken_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_write_addr_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              idex_en_o,
  output logic              exmem_en_o,
  output logic              memwb_en_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              memwb_bubble_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              dm_timeout_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int WCNT_W = $clog2(DM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(DM_TIMEOUT - 1);

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              dm_timeout_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic       dm_stall_s;
  logic       load_use_s;
  logic [1:0] fwd_a_raw_s;
  logic [1:0] fwd_b_raw_s;

  assign dm_stall_s = mem_access_i && !dm_ready_i;

  assign load_use_s = (ex_lwsrc_i == LW_MEM_SRC) && ex_reg_write_i &&
                      (ex_write_addr_i != {REG_AW{1'b0}}) &&
                      ((id_rs_used_i && (id_rs_addr_i == ex_write_addr_i)) ||
                       (id_rt_used_i && (id_rt_addr_i == ex_write_addr_i)));

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_src_addr_i    (ex_rs_addr_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_lwsrc_i      (mem_lwsrc_i),
    .mem_write_addr_i (mem_write_addr_i),
    .wb_reg_write_i   (wb_reg_write_i),
    .wb_write_addr_i  (wb_write_addr_i),
    .fwd_sel_o        (fwd_a_raw_s)
  );

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_src_addr_i    (ex_rt_addr_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_lwsrc_i      (mem_lwsrc_i),
    .mem_write_addr_i (mem_write_addr_i),
    .wb_reg_write_i   (wb_reg_write_i),
    .wb_write_addr_i  (wb_write_addr_i),
    .fwd_sel_o        (fwd_b_raw_s)
  );

  // Hazard priority: reset > error > memory stall > branch flush > load-use bubble
  always_comb begin
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    idex_en_o      = 1'b1;
    exmem_en_o     = 1'b1;
    memwb_en_o     = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    fwd_a_sel_o    = fwd_a_raw_s;
    fwd_b_sel_o    = fwd_b_raw_s;
    if (rst) begin
      pc_en_o     = 1'b0;
      ifid_en_o   = 1'b0;
      idex_en_o   = 1'b0;
      exmem_en_o  = 1'b0;
      memwb_en_o  = 1'b0;
      fwd_a_sel_o = FWD_RF;
      fwd_b_sel_o = FWD_RF;
    end else if (state_q == ST_ERR) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
      memwb_en_o = 1'b0;
    end else if (dm_stall_s) begin
      // Front of the pipe freezes (EX re-presents any branch later); MEM/WB drains a bubble
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      idex_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = WRITE_DISABLE;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use_s) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end else begin
      pc_en_o = 1'b1;
    end
  end

  // Controller FSM: tracks memory wait length and latches the timeout error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= {WCNT_W{1'b0}};
      dm_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dm_stall_s) begin
            state_q    <= ST_DM_WAIT;
            wait_cnt_q <= WCNT_W'(1);
          end else begin
            wait_cnt_q <= {WCNT_W{1'b0}};
          end
        end
        ST_DM_WAIT: begin
          if (dm_stall_s) begin
            if (wait_cnt_q == WAIT_LAST) begin
              state_q      <= ST_ERR;
              dm_timeout_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
            end
          end else begin
            state_q    <= ST_RUN;
            wait_cnt_q <= {WCNT_W{1'b0}};
          end
        end
        ST_ERR: begin
          dm_timeout_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_ERR;
          dm_timeout_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign dm_timeout_o = dm_timeout_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
